// File: rtl/button_debounce_4ch.sv
// button_debounce_4ch: four-channel synchronizer, debouncer and press/release pulse generator
module button_debounce_4ch #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       any_level
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [3:0] s1, s2, hit, stable_n;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] cnt_n [4];
  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = (s2[i] != btn_level[i]) && (cnt[i] == LAST);
      cnt_n[i] = (s2[i] == btn_level[i] || hit[i]) ? '0 : cnt[i] + CNT_W'(1);
    end
    stable_n = btn_level ^ hit;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      cnt <= '{default: '0};
      btn_level <= '0;
      btn_press <= '0;
      btn_release <= '0;
      any_level <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      cnt <= cnt_n;
      btn_level <= stable_n;
      btn_press <= hit & s2;
      btn_release <= hit & ~s2;
      any_level <= |stable_n;
    end
  end
endmodule

// File: tb/tb_button_debounce_4ch.sv
// tb_button_debounce_4ch: directed and random checks against a sliding-window debounce model
module tb_button_debounce_4ch;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_level, btn_press, btn_release;
  logic any_level;
  int checks = 0;
  int passes = 0;
  logic [3:0] rq [$];
  logic [3:0] sq [$];
  logic [3:0] m_level = '0;
  logic [3:0] m_press = '0;
  logic [3:0] m_rel = '0;
  logic [3:0] r;

  button_debounce_4ch #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .any_level(any_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
  endtask

  task automatic model_edge();
    logic [3:0] seen;
    logic all_mis;
    m_press = '0;
    m_rel = '0;
    if (!reset) begin
      rq = '{4'b0, 4'b0};
      sq.delete();
      m_level = '0;
    end else begin
      rq.push_back(btn_raw);
      seen = rq[0];
      rq.pop_front();
      sq.push_back(seen);
      if (sq.size() > N) sq.pop_front();
      for (int c = 0; c < 4; c++) begin
        all_mis = (sq.size() == N);
        foreach (sq[k]) if (sq[k][c] == m_level[c]) all_mis = 1'b0;
        if (all_mis) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_press[c] = 1'b1;
          else m_rel[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] raw, input logic rst);
    @(negedge clk);
    btn_raw = raw;
    reset = rst;
    model_edge();
    @(posedge clk);
    #1;
    chk("level", btn_level, m_level);
    chk("press", btn_press, m_press);
    chk("release", btn_release, m_rel);
    chk("any", {3'b0, any_level}, {3'b0, |m_level});
  endtask

  initial begin
    repeat (3) begin
      step(4'b0000, 1'b0);
      chk("rst_level", btn_level, 4'b0000);
      chk("rst_any", {3'b0, any_level}, 4'b0000);
    end
    for (int i = 1; i <= 7; i++) begin
      step(4'b0001, 1'b1);
      if (i == 5) chk("t1_level_e4", btn_level, 4'b0000);
      if (i == 6) begin
        chk("t1_level_e5", btn_level, 4'b0001);
        chk("t1_press_e5", btn_press, 4'b0001);
        chk("t1_any_e5", {3'b0, any_level}, 4'b0001);
      end
      if (i == 7) chk("t1_press_e6", btn_press, 4'b0000);
    end
    repeat (8) step(4'b0000, 1'b1);
    repeat (3) step(4'b0010, 1'b1);
    r = 4'b0000;
    for (int i = 0; i < 27; i++) begin
      step(r, 1'b1);
      chk("t2_quiet", btn_level | btn_press | btn_release, 4'b0000);
      if (i < 20) r = r ^ 4'b0010;
    end
    repeat (8) step(4'b0100, 1'b1);
    chk("t3_pre", btn_level, 4'b0100);
    for (int i = 1; i <= 6; i++) begin
      step(4'b0000, 1'b1);
      chk("t3_no_press", btn_press, 4'b0000);
      if (i == 5) chk("t3_level_e4", btn_level, 4'b0100);
      if (i == 6) begin
        chk("t3_level_e5", btn_level, 4'b0000);
        chk("t3_release_e5", btn_release, 4'b0100);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      step(4'b1010, 1'b1);
      if (i == 6) begin
        chk("t4_level", btn_level, 4'b1010);
        chk("t4_press", btn_press, 4'b1010);
      end
    end
    repeat (8) step(4'b0000, 1'b1);
    repeat (3) step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    chk("t5_rst_out", btn_level | btn_press | btn_release, 4'b0000);
    for (int i = 1; i <= 7; i++) begin
      step(4'b1000, 1'b1);
      if (i == 5) chk("t5_level_e4", btn_level, 4'b0000);
      if (i == 6) begin
        chk("t5_level_e5", btn_level, 4'b1000);
        chk("t5_press_e5", btn_press, 4'b1000);
      end
    end
    repeat (6) step(4'b0001, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(4'b0001, 1'b1);
      chk("t6_level", btn_level, 4'b0001);
      chk("t6_press", btn_press, 4'b0000);
    end
    chk("t6_cnt0", {2'b0, dut.cnt[0]}, 4'b0000);
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(5) == 0) r[c] = ~r[c];
      step(r, $urandom_range(99) != 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
